if_id_stage: RTL and testbench
==============================

IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 Parameter PC_W, 10, width of PC and instruction-memory address.
REQ-002 Parameter CNT_W, 16, width of the debug stall/flush counters.
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 enable  in  1  global run enable from the debug/UART controller; low freezes all state.
REQ-006 instruc  in  32  synchronous instruction-memory output; data for the address presented one cycle earlier.
REQ-007 PC_current  in  PC_W  address currently presented to instruction memory.
REQ-008 flush  in  1  redirect pending this cycle (branch taken or jump); the fetch unit loads the target on this edge.
REQ-009 id_ex_mem_read  in  1  the instruction in EX is a load.
REQ-010 id_ex_rt  in  5  destination register of that load.
REQ-011 PC_write  out  1  PC update permit to the fetch unit.
REQ-012 instruc_ID  out  32  instruction held for decode.
REQ-013 PC_ID  out  PC_W  address of instruc_ID.
REQ-014 valid_ID  out  1  instruc_ID is a real, non-squashed instruction.
REQ-015 bubble  out  1  zero ID/EX control this cycle.
REQ-016 stall_cnt, flush_cnt  out  CNT_W each  saturating debug event counters.

Function
REQ-017 pc_fetch SHALL register PC_current on every clock edge with enable=1, so instruc is always tagged by pc_fetch.
REQ-018 Hazard SHALL equal valid_ID & id_ex_mem_read & (id_ex_rt!=0) & (id_ex_rt==instruc_ID[25:21] | id_ex_rt==instruc_ID[20:16]).
REQ-019 stall SHALL equal hazard & !flush; flush has priority over stall.
REQ-020 PC_write SHALL equal !stall (combinational); bubble SHALL equal stall.
REQ-021 FSM states are FILL, RUN and SQUASH; all transitions require enable=1.
REQ-022 FILL: the next edge loads instruc_ID=NOP and valid_ID=0, then moves to RUN; flush in FILL moves to SQUASH.
REQ-023 RUN, flush: the edge loads valid_ID=0, instruc_ID=NOP and skid_valid=0, then moves to SQUASH.
REQ-024 RUN, stall, skid empty: instruc_ID and PC_ID hold; {instruc, pc_fetch} load into skid and skid_valid=1.
REQ-025 RUN, stall, skid full: instruc_ID, PC_ID and skid all hold.
REQ-026 RUN, no stall, skid full: the edge loads {instruc_ID, PC_ID} from skid with valid_ID=1 and skid_valid=0; live instruc is dropped.
REQ-027 RUN, no stall, skid empty: the edge loads {instruc, pc_fetch} with valid_ID=1.
REQ-028 SQUASH: the edge loads valid_ID=0 and instruc_ID=NOP, discarding the wrong-path word, then moves to RUN; flush in SQUASH stays in SQUASH.
REQ-029 Counters: +1 per enabled stall edge and per enabled flush edge; they SHALL saturate at all-ones and not wrap.
REQ-030 enable=0: no register changes; PC_write and bubble are still evaluated from the held state.

Reset
REQ-031 reset=1 SHALL immediately force state=FILL, instruc_ID=32'h0 (NOP), PC_ID=0, valid_ID=0, pc_fetch=0, skid_valid=0 and both counters to 0.
REQ-032 During and after reset PC_write=1 and bubble=0, because valid_ID=0.
REQ-033 Reset asserted mid-stall or mid-squash SHALL discard the skid and return to FILL with no partial update.

Structure
REQ-034 A shared package/include SHALL hold the FSM encodings, the NOP constant and the default widths, PC_W and CNT_W.
REQ-035 A single combinational sub-module, load_use_detect, SHALL implement REQ-018; all other logic is inline.

Verification
REQ-036 Reset release with memory words 0..3 = I0..I3 -> valid_ID=0 for the first enabled edge, then I0/PC_ID=0, I1/1 on consecutive cycles.
REQ-037 A load with rt=5 in EX while instruc_ID has rs=5 -> one cycle with PC_write=0 and bubble=1; the next instruction is delivered exactly once via skid; stall_cnt=1.
REQ-038 Hazard with id_ex_rt=0 -> no stall and PC_write=1.
REQ-039 flush in RUN with target 0x20 -> two valid_ID=0 cycles, then PC_ID=0x20; flush_cnt=1; simultaneous hazard ignored.
REQ-040 enable=0 for 3 cycles mid-stream -> all outputs frozen; the sequence resumes with no lost or duplicated instruction.
REQ-041 stall_cnt preloaded near all-ones, then 3 stalls -> the counter holds at 0xFFFF.

Source files
------------

// File: rtl/if_id_stage_pkg.sv
// Shared constants for the IF/ID pipeline register: FSM encodings, NOP word,
// default widths and small instruction-field helpers.
package if_id_stage_pkg;

    localparam int PC_W_DEFAULT  = 10;
    localparam int CNT_W_DEFAULT = 16;

    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam logic [4:0]  REG_ZERO = 5'd0;

    localparam logic [1:0] ST_FILL   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_SQUASH = 2'd2;

    function automatic logic [4:0] rs_of(input logic [31:0] instr);
        return instr[25:21];
    endfunction

    function automatic logic [4:0] rt_of(input logic [31:0] instr);
        return instr[20:16];
    endfunction

endpackage

// File: rtl/if_id_stage_load_use_detect.sv
// Load-use hazard detect: EX-stage load whose destination feeds the ID word.
// Latency: combinational.
// Backpressure: none; the result drives the stage stall.
module load_use_detect
    import if_id_stage_pkg::*;
(
    input  logic       valid_id,
    input  logic       mem_read,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       hazard
);

    // r0 is hardwired zero, so a load targeting it never creates a dependency.
    assign hazard = valid_id & mem_read & (ex_rt != REG_ZERO) &
                    ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with one-entry skid, flush squash and debug counters.
// Latency: one cycle from fetch tag (pc_fetch/instruc) to instruc_ID.
// Backpressure: load-use stall drops PC_write and parks the in-flight word in the skid.
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter int PC_W  = PC_W_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [31:0]      instruc,
    input  logic [PC_W-1:0]  PC_current,
    input  logic             flush,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_rt,
    output logic             PC_write,
    output logic [31:0]      instruc_ID,
    output logic [PC_W-1:0]  PC_ID,
    output logic             valid_ID,
    output logic             bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
    } fetch_t;

    logic [1:0]      state;
    logic [PC_W-1:0] pc_fetch;
    fetch_t          skid;
    logic            skid_valid;
    logic            hazard;
    logic            stall;

    load_use_detect u_load_use_detect (
        .valid_id (valid_ID),
        .mem_read (id_ex_mem_read),
        .ex_rt    (id_ex_rt),
        .id_rs    (rs_of(instruc_ID)),
        .id_rt    (rt_of(instruc_ID)),
        .hazard   (hazard)
    );

    // A redirect discards the dependent instruction anyway, so it wins over the stall.
    assign stall    = hazard & ~flush;
    assign PC_write = ~stall;
    assign bubble   = stall;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_FILL;
            pc_fetch   <= '0;
            instruc_ID <= NOP;
            PC_ID      <= '0;
            valid_ID   <= 1'b0;
            skid       <= '0;
            skid_valid <= 1'b0;
        end else if (enable) begin
            pc_fetch <= PC_current;
            case (state)
                ST_FILL: begin
                    instruc_ID <= NOP;
                    valid_ID   <= 1'b0;
                    skid_valid <= 1'b0;
                    state      <= flush ? ST_SQUASH : ST_RUN;
                end
                ST_RUN: begin
                    if (flush) begin
                        instruc_ID <= NOP;
                        valid_ID   <= 1'b0;
                        skid_valid <= 1'b0;
                        state      <= ST_SQUASH;
                    end else if (stall) begin
                        // PC is frozen this edge, so the word already in flight must be parked.
                        if (!skid_valid) begin
                            skid.instr <= instruc;
                            skid.pc    <= pc_fetch;
                            skid_valid <= 1'b1;
                        end
                    end else if (skid_valid) begin
                        // Memory is re-reading the held PC, so the live word is a duplicate.
                        instruc_ID <= skid.instr;
                        PC_ID      <= skid.pc;
                        valid_ID   <= 1'b1;
                        skid_valid <= 1'b0;
                    end else begin
                        instruc_ID <= instruc;
                        PC_ID      <= pc_fetch;
                        valid_ID   <= 1'b1;
                    end
                end
                ST_SQUASH: begin
                    instruc_ID <= NOP;
                    valid_ID   <= 1'b0;
                    skid_valid <= 1'b0;
                    state      <= flush ? ST_SQUASH : ST_RUN;
                end
                default: begin
                    instruc_ID <= NOP;
                    valid_ID   <= 1'b0;
                    skid_valid <= 1'b0;
                    state      <= ST_FILL;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (enable) begin
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed fetch stream with a scoreboard of expected
// {instruction, PC} deliveries checked by an independent monitor.
module tb_if_id_stage;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [31:0] instruc;
    logic [9:0]  PC_current;
    logic        flush;
    logic        id_ex_mem_read;
    logic [4:0]  id_ex_rt;
    logic        PC_write;
    logic [31:0] instruc_ID;
    logic [9:0]  PC_ID;
    logic        valid_ID;
    logic        bubble;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    logic        sat_PC_write;
    logic [31:0] sat_instruc_ID;
    logic [9:0]  sat_PC_ID;
    logic        sat_valid_ID;
    logic        sat_bubble;
    logic [3:0]  sat_stall_cnt;
    logic [3:0]  sat_flush_cnt;

    logic [31:0] mem [0:1023];
    logic [9:0]  pc;
    logic [9:0]  flush_tgt;
    logic [41:0] sb [$];
    int          nerr;
    int          nchk;

    if_id_stage #(.PC_W(10), .CNT_W(16)) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .instruc        (instruc),
        .PC_current     (PC_current),
        .flush          (flush),
        .id_ex_mem_read (id_ex_mem_read),
        .id_ex_rt       (id_ex_rt),
        .PC_write       (PC_write),
        .instruc_ID     (instruc_ID),
        .PC_ID          (PC_ID),
        .valid_ID       (valid_ID),
        .bubble         (bubble),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    // Narrow-counter twin driven identically, so saturation is reachable quickly.
    if_id_stage #(.PC_W(10), .CNT_W(4)) dut_sat (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .instruc        (instruc),
        .PC_current     (PC_current),
        .flush          (flush),
        .id_ex_mem_read (id_ex_mem_read),
        .id_ex_rt       (id_ex_rt),
        .PC_write       (sat_PC_write),
        .instruc_ID     (sat_instruc_ID),
        .PC_ID          (sat_PC_ID),
        .valid_ID       (sat_valid_ID),
        .bubble         (sat_bubble),
        .stall_cnt      (sat_stall_cnt),
        .flush_cnt      (sat_flush_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mk(input int a);
        logic [4:0] rs;
        logic [9:0] lo;
        rs = 5'd1;
        if (a == 4) rs = 5'd5;
        if (a == 6) rs = 5'd0;
        lo = a[9:0];
        return {6'h23, rs, 5'd2, 6'd0, lo};
    endfunction

    function automatic logic [41:0] ent(input int a);
        logic [9:0] p;
        p = a[9:0];
        return {mk(a), p};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a falling edge with inputs set; models PC register + synchronous memory.
    task automatic tick();
        logic        pw;
        logic [9:0]  np;
        logic [31:0] ni;
        #1;
        pw = PC_write;
        np = flush ? flush_tgt : (pw ? pc + 10'd1 : pc);
        ni = mem[pc];
        @(posedge clock);
        #1;
        if (enable) begin
            pc         = np;
            PC_current = np;
            instruc    = ni;
        end
        @(negedge clock);
    endtask

    // An instruction is consumed by decode on an enabled edge where it is valid and not stalled.
    initial begin
        logic [41:0] e;
        forever begin
            @(negedge clock);
            #3;
            if (!reset && enable && valid_ID && !bubble) begin
                nchk++;
                if (sb.size() == 0) begin
                    nerr++;
                    $display("FAIL sb_extra: got %0h/%0h expected no delivery", instruc_ID, PC_ID);
                end else begin
                    e = sb.pop_front();
                    if ({instruc_ID, PC_ID} !== e) begin
                        nerr++;
                        $display("FAIL sb_deliver: got %0h/%0h expected %0h/%0h",
                                 instruc_ID, PC_ID, e[41:10], e[9:0]);
                    end
                end
            end
        end
    end

    initial begin
        nerr = 0;
        nchk = 0;
        for (int a = 0; a < 1024; a++) mem[a] = mk(a);
        reset = 1'b1; enable = 1'b0; flush = 1'b0; flush_tgt = '0;
        id_ex_mem_read = 1'b0; id_ex_rt = '0;
        PC_current = '0; instruc = '0; pc = '0;
        repeat (2) @(negedge clock);
        #1;
        chk("rst_pc_write", PC_write, 1);
        chk("rst_bubble", bubble, 0);
        chk("rst_valid", valid_ID, 0);
        chk("rst_instr", instruc_ID, 0);
        chk("rst_pc_id", PC_ID, 0);
        chk("rst_cnts", {stall_cnt, flush_cnt}, 0);

        @(negedge clock);
        reset = 1'b0;
        enable = 1'b1;
        for (int a = 0; a <= 10; a++) sb.push_back(ent(a));
        sb.push_back(ent(32'h20));
        sb.push_back(ent(32'h21));
        sb.push_back(ent(32'h22));

        tick();
        chk("fill_valid", valid_ID, 0);
        chk("fill_nop", instruc_ID, 0);
        repeat (5) tick();
        chk("id_i4", {instruc_ID, PC_ID}, ent(4));

        // load-use on rs
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd5;
        #1;
        chk("stall_pc_write", PC_write, 0);
        chk("stall_bubble", bubble, 1);
        tick();
        id_ex_mem_read = 1'b0; id_ex_rt = 5'd0;
        chk("stall_hold", {instruc_ID, PC_ID}, ent(4));
        chk("stall_cnt_1", stall_cnt, 1);
        tick();
        tick();

        // load into r0 against an rs=0 instruction
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd0;
        #1;
        chk("r0_pc_write", PC_write, 1);
        chk("r0_bubble", bubble, 0);
        tick();
        id_ex_mem_read = 1'b0;
        tick();

        // freeze, including a hazard seen while disabled
        enable = 1'b0;
        tick();
        chk("frz1", {instruc_ID, PC_ID, valid_ID}, {ent(8), 1'b1});
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd1;
        #1;
        chk("frz_pc_write", PC_write, 0);
        tick();
        id_ex_mem_read = 1'b0;
        chk("frz2", {instruc_ID, PC_ID, valid_ID}, {ent(8), 1'b1});
        chk("frz_stall_cnt", stall_cnt, 1);
        tick();
        chk("frz3", {instruc_ID, PC_ID, valid_ID}, {ent(8), 1'b1});
        enable = 1'b1;
        tick();
        tick();

        // redirect with a simultaneous hazard
        flush = 1'b1; flush_tgt = 10'h20; id_ex_mem_read = 1'b1; id_ex_rt = 5'd1;
        #1;
        chk("flush_pc_write", PC_write, 1);
        chk("flush_bubble", bubble, 0);
        tick();
        flush = 1'b0; id_ex_mem_read = 1'b0;
        chk("flush_valid", valid_ID, 0);
        chk("flush_nop", instruc_ID, 0);
        chk("flush_cnt_1", flush_cnt, 1);
        chk("flush_no_stall", stall_cnt, 1);
        tick();
        chk("squash_valid", valid_ID, 0);
        tick();
        chk("target", {instruc_ID, PC_ID, valid_ID}, {ent(32'h20), 1'b1});
        tick();

        // sustained stall drives the narrow counter into saturation
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd1;
        repeat (12) tick();
        chk("sat_pre", sat_stall_cnt, 13);
        repeat (3) tick();
        chk("sat_hold", sat_stall_cnt, 4'hF);
        chk("cnt_16", stall_cnt, 16);
        chk("sat_flush_cnt", sat_flush_cnt, 1);
        chk("sat_state", {sat_instruc_ID, sat_PC_ID, sat_valid_ID, sat_bubble, sat_PC_write},
            {ent(32'h21), 1'b1, 1'b1, 1'b0});
        chk("long_stall_hold", {instruc_ID, PC_ID}, ent(32'h21));
        id_ex_mem_read = 1'b0;
        tick();
        tick();

        // reset in the middle of a stall with the skid loaded
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd2;
        tick();
        chk("cnt_17", stall_cnt, 17);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", valid_ID, 0);
        chk("mid_rst_id", {instruc_ID, PC_ID}, 0);
        chk("mid_rst_cnts", {stall_cnt, flush_cnt}, 0);
        chk("mid_rst_pc_write", PC_write, 1);
        chk("mid_rst_bubble", bubble, 0);
        pc = '0; PC_current = '0; instruc = '0; id_ex_mem_read = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        sb.push_back(ent(32'h40));
        sb.push_back(ent(32'h41));

        // flush in FILL, then again in SQUASH
        flush = 1'b1; flush_tgt = 10'h30;
        tick();
        chk("fill_flush_valid", valid_ID, 0);
        flush_tgt = 10'h40;
        tick();
        flush = 1'b0;
        chk("sq_flush_valid", valid_ID, 0);
        chk("flush_cnt_2", flush_cnt, 2);
        tick();
        chk("sq_exit_valid", valid_ID, 0);
        tick();
        chk("target2", {instruc_ID, PC_ID, valid_ID}, {ent(32'h40), 1'b1});
        tick();
        tick();
        chk("sb_drain", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
